lsu: RTL and testbench

Load/store unit between the core's execute stage and the byte-addressed `ram` block (main memory plus the 0xFFF00000 I/O window). It accepts one memory request at a time over a valid/ready handshake and drives `ram`'s `we`/`addr`/`wd` encoding. For loads it samples `ram`'s combinational read data and sign- or zero-extends it. It returns a response, with an error flag, over a second valid/ready handshake.

---
 rtl/lsu.sv | 127 ++++++++++++
 tb/tb_lsu.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: single outstanding request to the byte-addressed ram, with sign/zero-extended loads.
// Optional LSU_MISALIGN_TRAP_EN rejects misaligned half/word accesses as errors.
module lsu #(
    parameter int LOAD_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_data,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; the
    // producer holds its payload stable while valid is high and ready is low.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [1:0] WAIT_INIT = LOAD_WAIT[1:0];

    state_t      state_q, state_d;
    logic [1:0]  wait_q;
    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        req_illegal;
    logic [31:0] load_ext;

    always_comb begin
        req_illegal = (req_size == 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_size == 2'b10 && req_addr[0]) ||
            (req_size == 2'b11 && req_addr[1:0] != 2'b00))
            req_illegal = 1'b1;
`endif
    end

    always_comb begin
        case (lat_size)
            2'b01:   load_ext = {{24{~lat_unsigned & mem_data[7]}}, mem_data[7:0]};
            2'b10:   load_ext = {{16{~lat_unsigned & mem_data[15]}}, mem_data[15:0]};
            default: load_ext = mem_data;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_valid) state_d = req_illegal ? S_RESP : S_ACCESS;
            S_ACCESS: if (lat_we || wait_q == 2'd0) state_d = S_RESP;
            S_RESP:   if (resp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q       <= 2'd0;
            lat_we       <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_addr     <= 32'h0;
            lat_wdata    <= 32'h0;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_we       <= req_we;
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_addr     <= req_addr;
                        lat_wdata    <= req_wdata;
                        wait_q       <= WAIT_INIT;
                        rdata_q      <= 32'h0;
                        err_q        <= req_illegal;
                    end
                end
                S_ACCESS: begin
                    // Stores leave rdata_q at the zero loaded on accept.
                    if (!lat_we) begin
                        if (wait_q != 2'd0) wait_q  <= wait_q - 2'd1;
                        else                rdata_q <= load_ext;
                    end
                end
                default: ;
            endcase
        end
    end

    // rst gates the write strobe directly so a store cut mid-cycle never reaches ram.
    assign mem_we     = (state_q == S_ACCESS && lat_we && !rst) ? lat_size : 2'b00;
    assign mem_addr   = lat_addr;
    assign mem_wd     = lat_wdata;
    assign req_ready  = (state_q == S_IDLE) && !rst;
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: a byte-array ram model plus an independent reference memory/scoreboard.
module tb_lsu;
    localparam int LW = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [1:0]  mem_we;
    logic [31:0] mem_addr, mem_wd, mem_data;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  ram_mem [256];
    logic [7:0]  led;
    logic [7:0]  ref_mem [256];
    logic [7:0]  ref_led;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    lsu #(.LOAD_WAIT(LW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_data(mem_data), .dbg_state(dbg_state)
    );

    // ram: 256-byte main memory (address bits above 7 ignored) and an LED register in the I/O window.
    assign mem_data = (mem_addr[31:20] == 12'hFFF) ? 32'h0 :
        {ram_mem[8'(mem_addr[7:0] + 8'd3)], ram_mem[8'(mem_addr[7:0] + 8'd2)],
         ram_mem[8'(mem_addr[7:0] + 8'd1)], ram_mem[mem_addr[7:0]]};

    always @(posedge clk) begin
        if (mem_we != 2'b00) begin
            if (mem_addr[31:20] == 12'hFFF) led <= mem_wd[7:0];
            else begin
                for (int k = 0; k < 4; k++)
                    if (k < ((mem_we == 2'b01) ? 1 : (mem_we == 2'b10) ? 2 : 4))
                        ram_mem[8'(mem_addr[7:0] + 8'(k))] <= mem_wd[8*k +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int size_bytes(input logic [1:0] size);
        return (size == 2'b01) ? 1 : (size == 2'b10) ? 2 : 4;
    endfunction

    function automatic logic is_io(input logic [31:0] addr);
        return addr[31:20] == 12'hFFF;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                               input logic uns);
        logic [31:0] w;
        logic [31:0] v;
        w = 32'h0;
        if (!is_io(addr))
            for (int k = 0; k < 4; k++) w = w + (32'(ref_mem[8'(addr[7:0] + 8'(k))]) << (8 * k));
        if (size == 2'b01) begin
            v = w % 256;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (size == 2'b10) begin
            v = w % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else v = w;
        return v;
    endfunction

    function automatic logic model_illegal(input logic [1:0] size, input logic [31:0] addr);
        logic bad;
        bad = (size == 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
        if (size == 2'b10 && addr % 2 != 0) bad = 1'b1;
        if (size == 2'b11 && addr % 4 != 0) bad = 1'b1;
`else
        if (addr == 32'hFFFF_FFFF && size == 2'b00) bad = 1'b1;
`endif
        return bad;
    endfunction

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input int hold);
        logic        bad;
        int          exp_lat, cyc, writes;
        logic [1:0]  seen_we;
        logic [31:0] seen_addr, seen_wd, first_rdata;
        logic [32:0] exp;

        bad = model_illegal(size, addr);
        if (bad) exp = {1'b1, 32'h0};
        else if (we) begin
            exp = {1'b0, 32'h0};
            if (is_io(addr)) ref_led = wd[7:0];
            else
                for (int k = 0; k < size_bytes(size); k++)
                    ref_mem[8'(addr[7:0] + 8'(k))] = wd[8*k +: 8];
        end else exp = {1'b0, model_load(addr, size, uns)};
        exp_q.push_back(exp);
        exp_lat = bad ? 1 : (we ? 2 : 2 + LW);

        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        resp_ready = (hold == 0);
        @(negedge clk);
        req_valid = 1'b0; req_we = $urandom_range(0, 1); req_size = 2'($urandom_range(0, 3));
        req_addr = $urandom; req_wdata = $urandom;
        cyc = 1; writes = 0; seen_we = 2'b00; seen_addr = 32'h0; seen_wd = 32'h0;
        while (!resp_valid && cyc < 40) begin
            if (mem_we != 2'b00) begin
                writes++; seen_we = mem_we; seen_addr = mem_addr; seen_wd = mem_wd;
            end
            check("req_ready_busy", 32'(req_ready), 32'd0);
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'(exp_lat));
        check("write_count", 32'(writes), (we && !bad) ? 32'd1 : 32'd0);
        if (we && !bad) begin
            check("mem_we", 32'(seen_we), 32'(size));
            check("mem_addr_st", seen_addr, addr);
            check("mem_wd", seen_wd, wd);
        end
        check("mem_addr_hold", mem_addr, addr);
        exp = exp_q.pop_front();
        check("resp_err", 32'(resp_err), 32'(exp[32]));
        check("resp_rdata", resp_rdata, exp[31:0]);
        first_rdata = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_rdata", resp_rdata, first_rdata);
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_we", 32'(mem_we), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_drop", 32'(resp_valid), 32'd0);
        if (we && !bad && is_io(addr)) check("led", 32'(led), 32'(ref_led));
    endtask

    task automatic reset_mid_store();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b11; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_pre_we", 32'(mem_we), 32'd3);
        #1 rst = 1'b1;
        #1;
        check("rst_async_we", 32'(mem_we), 32'd0);
        check("rst_async_valid", 32'(resp_valid), 32'd0);
        check("rst_async_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        led = 8'h00; ref_led = 8'h00;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_resp_err", 32'(resp_err), 32'd0);
        check("reset_resp_rdata", resp_rdata, 32'h0);
        check("reset_mem_we", 32'(mem_we), 32'd0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_mem_wd", mem_wd, 32'h0);
        rst = 1'b0;
        #1;
        check("release_req_ready", 32'(req_ready), 32'd1);

        do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'h8000_00F1, 0);
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1);
        do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 0);
        do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 0);
        do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 0);
        do_req(1'b0, 2'b10, 1'b1, 32'h12, 32'h0, 0);
        do_req(1'b1, 2'b01, 1'b0, 32'hFFF0_0000, 32'h0000_0005, 0);
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 5);
        do_req(1'b1, 2'b00, 1'b0, 32'h20, 32'h1234_5678, 2);
        do_req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 0);
        do_req(1'b1, 2'b10, 1'b0, 32'h11, 32'hCAFE_BABE, 0);
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0);
        do_req(1'b0, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0, 0);

        reset_mid_store();
        do_req(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 0);

        for (int t = 0; t < 150; t++) begin
            logic        we;
            logic [1:0]  size;
            logic [31:0] addr;
            we   = $urandom_range(0, 1);
            size = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            addr = ($urandom_range(0, 15) == 0) ? 32'hFFF0_0000 : 32'($urandom_range(0, 255));
            do_req(we, size, 1'($urandom_range(0, 1)), addr, $urandom, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
